traffic_lamp_decoder: RTL and testbench

Receiving end of the controller's 4-bit `light_signal` bus. Decodes each code into registered red/yellow/green lamp drives for the four approaches (NS, SN, EW, WE). Checks the code stream against the controller's sequencing rules. Any illegal code, illegal transition or overlong green latches a sticky fault, and the lamps are forced to flashing red. Sits between the traffic light FSM and the lamp power drivers.

---
 rtl/traffic_lamp_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_traffic_lamp_decoder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/traffic_lamp_decoder.sv
// traffic_lamp_decoder
// Decodes the controller's 4-bit light code into registered lamp drives for
// the four approaches (NS, SN, EW, WE). It also watches the code stream for
// illegal codes, illegal transitions and overlong greens. Any of these latches
// a sticky fault, and the lamps then flash red until a clear is accepted.

module traffic_lamp_decoder #(
    parameter int MAX_GREEN  = 2,  // max consecutive cycles a green code may be held (>= 1)
    parameter int FLASH_HALF = 4   // cycles per half-period of fault-mode red flashing (>= 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] light_signal,
    input  logic       fault_clr,
    output logic [2:0] ns_lamp,
    output logic [2:0] sn_lamp,
    output logic [2:0] ew_lamp,
    output logic [2:0] we_lamp,
    output logic       fault,
    output logic [1:0] fault_cause
);

    localparam int HOLD_W  = $clog2(MAX_GREEN + 2);
    localparam int FLASH_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LIMIT = HOLD_W'(MAX_GREEN);
    localparam logic [HOLD_W-1:0]  HOLD_SAT   = {HOLD_W{1'b1}};
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_HALF - 1);

    // Lamp encoding is {red, yellow, green}.
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef enum logic {
        ST_NORMAL,
        ST_FAULT
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE         = 2'b00,
        CAUSE_ILLEGAL_CODE = 2'b01,
        CAUSE_BAD_TRANS    = 2'b10,
        CAUSE_TIMEOUT      = 2'b11
    } cause_t;

    // Lane index: 0 = NS, 1 = SN, 2 = EW, 3 = WE.
    typedef logic [3:0][2:0] lamps_t;

    localparam lamps_t ALL_RED = {4{LAMP_RED}};

    state_t            state_q, state_d;
    cause_t            cause_q, cause_d;
    logic [3:0]        prev_code_q, prev_code_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
    logic              flash_phase_q, flash_phase_d;
    logic              fault_q, fault_d;
    lamps_t            lamps_q, lamps_d;

    cause_t            cause_det;

    // Green codes are the odd codes 1, 3, 5 and 7.
    function automatic logic is_green(input logic [3:0] code);
        return (code inside {4'd1, 4'd3, 4'd5, 4'd7});
    endfunction

    // Sequencing rules: 0 -> 0/green, green k -> green k/yellow k, yellow k -> yellow k/0.
    function automatic logic legal_transition(input logic [3:0] prev, input logic [3:0] cur);
        logic ok;
        if (prev == 4'd0) begin
            ok = (cur == 4'd0) || is_green(cur);
        end else if (is_green(prev)) begin
            ok = (cur == prev) || (cur == prev + 4'd1);
        end else begin
            ok = (cur == prev) || (cur == 4'd0);
        end
        return ok;
    endfunction

    // Normal-mode decode: the addressed lane shows green or yellow, all others red.
    function automatic lamps_t decode(input logic [3:0] code);
        lamps_t     l;
        logic [3:0] idx;
        l = ALL_RED;
        if (code >= 4'd1 && code <= 4'd8) begin
            idx = (code - 4'd1) >> 1;
            l[idx[1:0]] = code[0] ? LAMP_GREEN : LAMP_YELLOW;
        end
        return l;
    endfunction

    // Classify the current code against the stream rules, in priority order.
    always_comb begin
        cause_det = CAUSE_NONE;
        if (light_signal >= 4'd9) begin
            cause_det = CAUSE_ILLEGAL_CODE;
        end else if (!legal_transition(prev_code_q, light_signal)) begin
            cause_det = CAUSE_BAD_TRANS;
        end else if ((light_signal == prev_code_q) && is_green(light_signal) &&
                     (hold_cnt_q == HOLD_LIMIT)) begin
            cause_det = CAUSE_TIMEOUT;
        end
    end

    // Next-state, lamp and flag logic for the NORMAL/FAULT machine.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a signal unassigned and infer a latch.
        state_d       = state_q;
        cause_d       = cause_q;
        prev_code_d   = prev_code_q;
        hold_cnt_d    = hold_cnt_q;
        flash_cnt_d   = flash_cnt_q;
        flash_phase_d = flash_phase_q;
        fault_d       = fault_q;
        lamps_d       = lamps_q;

        unique case (state_q)
            ST_NORMAL: begin
                if (cause_det != CAUSE_NONE) begin
                    // Fault entry: prev_code and hold_cnt stay frozen.
                    state_d       = ST_FAULT;
                    fault_d       = 1'b1;
                    cause_d       = cause_det;
                    lamps_d       = ALL_RED;
                    flash_cnt_d   = '0;
                    flash_phase_d = 1'b1;
                end else begin
                    lamps_d     = decode(light_signal);
                    prev_code_d = light_signal;
                    if (!is_green(light_signal)) begin
                        hold_cnt_d = '0;
                    end else if (light_signal != prev_code_q) begin
                        hold_cnt_d = HOLD_W'(1);
                    end else if (hold_cnt_q != HOLD_SAT) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
            end

            ST_FAULT: begin
                if (fault_clr && (light_signal == 4'd0)) begin
                    state_d       = ST_NORMAL;
                    fault_d       = 1'b0;
                    cause_d       = CAUSE_NONE;
                    prev_code_d   = '0;
                    hold_cnt_d    = '0;
                    lamps_d       = ALL_RED;
                    flash_cnt_d   = '0;
                    flash_phase_d = 1'b1;
                end else begin
                    if (flash_cnt_q == FLASH_LAST) begin
                        flash_cnt_d   = '0;
                        flash_phase_d = ~flash_phase_q;
                    end else begin
                        flash_cnt_d = flash_cnt_q + FLASH_W'(1);
                    end
                    // Lamps follow the phase being registered this edge, so the
                    // red half-period starts exactly at the toggle edge.
                    lamps_d = {4{flash_phase_d, 2'b00}};
                end
            end

            default: begin
                state_d = ST_NORMAL;
            end
        endcase
    end

    // State and output registers; synchronous reset has top priority.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            // NOTE: every register here is a plain flop, so all of them are reset;
            // the lamp drives must show all-red from the first cycle.
            state_q       <= ST_NORMAL;
            cause_q       <= CAUSE_NONE;
            prev_code_q   <= '0;
            hold_cnt_q    <= '0;
            flash_cnt_q   <= '0;
            flash_phase_q <= 1'b1;
            fault_q       <= 1'b0;
            lamps_q       <= ALL_RED;
        end else begin
            state_q       <= state_d;
            cause_q       <= cause_d;
            prev_code_q   <= prev_code_d;
            hold_cnt_q    <= hold_cnt_d;
            flash_cnt_q   <= flash_cnt_d;
            flash_phase_q <= flash_phase_d;
            fault_q       <= fault_d;
            lamps_q       <= lamps_d;
        end
    end

    assign ns_lamp     = lamps_q[0];
    assign sn_lamp     = lamps_q[1];
    assign ew_lamp     = lamps_q[2];
    assign we_lamp     = lamps_q[3];
    assign fault       = fault_q;
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_traffic_lamp_decoder.sv
// Directed testbench for traffic_lamp_decoder with hand-computed lamp patterns.
// Lamps are compared as one 12-bit word {ns, sn, ew, we}, each {red, yellow, green}.

module tb_traffic_lamp_decoder;

    localparam logic [11:0] L_RED  = 12'h924;  // all approaches red
    localparam logic [11:0] L_DARK = 12'h000;  // fault flash, red off
    localparam logic [11:0] L_NS_G = 12'h324;
    localparam logic [11:0] L_NS_Y = 12'h524;
    localparam logic [11:0] L_SN_G = 12'h864;
    localparam logic [11:0] L_SN_Y = 12'h8A4;
    localparam logic [11:0] L_EW_G = 12'h90C;
    localparam logic [11:0] L_WE_G = 12'h921;
    localparam logic [11:0] L_WE_Y = 12'h922;

    logic       clk;
    logic       rst;
    logic [3:0] light_signal;
    logic       fault_clr;
    logic [2:0] ns_lamp, sn_lamp, ew_lamp, we_lamp;
    logic       fault;
    logic [1:0] fault_cause;
    logic [11:0] lamps;

    int n_checks;
    int n_errors;

    traffic_lamp_decoder #(
        .MAX_GREEN (2),
        .FLASH_HALF(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .light_signal(light_signal),
        .fault_clr   (fault_clr),
        .ns_lamp     (ns_lamp),
        .sn_lamp     (sn_lamp),
        .ew_lamp     (ew_lamp),
        .we_lamp     (we_lamp),
        .fault       (fault),
        .fault_cause (fault_cause)
    );

    assign lamps = {ns_lamp, sn_lamp, ew_lamp, we_lamp};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply inputs, take one rising edge, then settle 1 time unit before sampling.
    task automatic step(input logic [3:0] code, input logic clr, input logic r);
        light_signal = code;
        fault_clr    = clr;
        rst          = r;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [11:0] exp_lamps,
                                input logic exp_fault, input logic [1:0] exp_cause);
        check({tag, ".lamps"}, lamps, exp_lamps);
        check({tag, ".fault"}, {11'd0, fault}, {11'd0, exp_fault});
        check({tag, ".cause"}, {10'd0, fault_cause}, {10'd0, exp_cause});
    endtask

    logic [3:0]  seq_code [8];
    logic [11:0] seq_lamp [8];

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        light_signal = 4'd0;
        fault_clr    = 1'b0;
        rst          = 1'b1;

        // Reset state.
        step(4'd0, 1'b0, 1'b1);
        step(4'd0, 1'b0, 1'b1);
        expect_state("reset", L_RED, 1'b0, 2'b00);

        // Normal sequence 0,1,1,2,0,3,4,0.
        seq_code = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd0, 4'd3, 4'd4, 4'd0};
        seq_lamp = '{L_RED, L_NS_G, L_NS_G, L_NS_Y, L_RED, L_SN_G, L_SN_Y, L_RED};
        for (int i = 0; i < 8; i++) begin
            step(seq_code[i], 1'b0, 1'b0);
            expect_state($sformatf("seq%0d", i), seq_lamp[i], 1'b0, 2'b00);
        end

        // fault_clr in NORMAL has no effect.
        step(4'd0, 1'b1, 1'b0);
        expect_state("clr_normal", L_RED, 1'b0, 2'b00);

        // Green of another lane: illegal transition, EW green never shows.
        step(4'd1, 1'b0, 1'b0);
        expect_state("trans_ns", L_NS_G, 1'b0, 2'b00);
        step(4'd5, 1'b0, 1'b0);
        expect_state("trans_bad", L_RED, 1'b1, 2'b10);
        step(4'd0, 1'b1, 1'b0);
        expect_state("trans_clr", L_RED, 1'b0, 2'b00);

        // Illegal code, then an illegal transition must not overwrite the cause.
        step(4'd12, 1'b0, 1'b0);
        expect_state("code12", L_RED, 1'b1, 2'b01);
        step(4'd2, 1'b0, 1'b0);
        expect_state("code12_sticky", L_RED, 1'b1, 2'b01);
        step(4'd0, 1'b1, 1'b0);
        expect_state("code12_clr", L_RED, 1'b0, 2'b00);

        // Green timeout: third consecutive 7 with MAX_GREEN=2.
        step(4'd7, 1'b0, 1'b0);
        expect_state("to_7a", L_WE_G, 1'b0, 2'b00);
        step(4'd7, 1'b0, 1'b0);
        expect_state("to_7b", L_WE_G, 1'b0, 2'b00);
        step(4'd7, 1'b0, 1'b0);
        expect_state("to_7c", L_RED, 1'b1, 2'b11);
        step(4'd0, 1'b1, 1'b0);
        expect_state("to_clr", L_RED, 1'b0, 2'b00);

        // 7,7,8,0 is legal.
        step(4'd7, 1'b0, 1'b0);
        expect_state("ok_7a", L_WE_G, 1'b0, 2'b00);
        step(4'd7, 1'b0, 1'b0);
        expect_state("ok_7b", L_WE_G, 1'b0, 2'b00);
        step(4'd8, 1'b0, 1'b0);
        expect_state("ok_8", L_WE_Y, 1'b0, 2'b00);
        step(4'd0, 1'b0, 1'b0);
        expect_state("ok_0", L_RED, 1'b0, 2'b00);

        // Flash timing: enter fault with code 9, red on 4 cycles, off 4, on again.
        // fault_clr with a nonzero code is ignored throughout.
        step(4'd9, 1'b0, 1'b0);
        expect_state("flash0", L_RED, 1'b1, 2'b01);
        for (int k = 1; k <= 12; k++) begin
            step(4'd3, 1'b1, 1'b0);
            expect_state($sformatf("flash%0d", k),
                         (((k / 4) % 2) == 0) ? L_RED : L_DARK, 1'b1, 2'b01);
        end
        step(4'd0, 1'b1, 1'b0);
        expect_state("flash_clr", L_RED, 1'b0, 2'b00);
        step(4'd1, 1'b0, 1'b0);
        expect_state("post_clr_ns", L_NS_G, 1'b0, 2'b00);

        // Reset during the red-off phase of fault mode.
        step(4'd5, 1'b0, 1'b0);
        expect_state("rf_entry", L_RED, 1'b1, 2'b10);
        for (int k = 1; k <= 4; k++) begin
            step(4'd0, 1'b0, 1'b0);
        end
        expect_state("rf_dark", L_DARK, 1'b1, 2'b10);
        step(4'd0, 1'b0, 1'b1);
        expect_state("rf_reset", L_RED, 1'b0, 2'b00);
        step(4'd5, 1'b0, 1'b0);
        expect_state("rf_ew", L_EW_G, 1'b0, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
